// File: rtl/act_buf_sched_pkg.sv
// Shared parameters for the activation double-buffer scheduler.
//   INPUT_CHANNEL_ADDR_SIZE : default activation memory address width
//                             (the MSB selects buffer 0 or buffer 1)
//   ACT_SCHED_LAYER_W       : default layer-count width
//   act_sched_state_t       : scheduler FSM state encoding
package act_buf_sched_pkg;

  localparam int INPUT_CHANNEL_ADDR_SIZE = 10;
  localparam int ACT_SCHED_LAYER_W       = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOAD = 3'd1,
    S_START     = 3'd2,
    S_RUN       = 3'd3,
    S_SWAP      = 3'd4,
    S_DONE      = 3'd5
  } act_sched_state_t;

endpackage

// File: rtl/act_buf_sched.sv
// act_buf_sched: ping-pong activation buffer scheduler.
// Runs a configured number of layers on an external engine. Each layer reads
// its input from one half of the activation memory and writes its output into
// the other half; the halves swap after every layer, so the final result ends
// up in the half reported on result_buf.
//
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   cfg_valid/cfg_ready   : config handshake (accepted only in IDLE)
//   cfg_n_layers          : number of layers to run (0 finishes immediately)
//   cfg_in_base/out_base  : offsets inside a buffer half
//   load_done             : first input has been written into buffer 0
//   layer_start           : one-cycle pulse, engine may begin a layer
//   layer_done            : engine finished the current layer
//   input/output_memory_pointer : {buffer select, offset} for the engine
//   abort                 : drop the job and return to IDLE without done
//   busy, done, layer_idx, result_buf, host_acc_ok : status
//   state_dbg             : registered FSM state for observation
//
// Handshake: a config transfer happens on a rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready is high only in IDLE, and cfg_valid is
// ignored in every other state.
module act_buf_sched
  import act_buf_sched_pkg::*;
#(
  parameter int ADDR_W  = INPUT_CHANNEL_ADDR_SIZE,
  parameter int LAYER_W = ACT_SCHED_LAYER_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [LAYER_W-1:0] cfg_n_layers,
  input  logic [ADDR_W-2:0]  cfg_in_base,
  input  logic [ADDR_W-2:0]  cfg_out_base,
  input  logic               load_done,
  output logic               layer_start,
  input  logic               layer_done,
  output logic [ADDR_W-1:0]  input_memory_pointer,
  output logic [ADDR_W-1:0]  output_memory_pointer,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               result_buf,
  output logic               host_acc_ok,
  output logic [2:0]         state_dbg
);

  act_sched_state_t   state, state_next;
  logic               in_sel;
  logic [LAYER_W-1:0] n_layers;
  logic [ADDR_W-2:0]  in_base;
  logic [ADDR_W-2:0]  out_base;
  logic               last_layer;

  // n_layers is never 0 in SWAP (a zero count goes straight to DONE), so the
  // subtraction cannot wrap there; the full LAYER_W range runs without wrap.
  assign last_layer = (layer_idx == (n_layers - LAYER_W'(1)));

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (cfg_valid) begin
          state_next = (cfg_n_layers == '0) ? S_DONE : S_WAIT_LOAD;
        end
      end
      S_WAIT_LOAD: if (load_done)  state_next = S_START;
      S_START:                     state_next = S_RUN;
      S_RUN:       if (layer_done) state_next = S_SWAP;
      S_SWAP:      state_next = last_layer ? S_DONE : S_START;
      S_DONE:                      state_next = S_IDLE;
      default:                     state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      in_sel     <= 1'b0;
      layer_idx  <= '0;
      result_buf <= 1'b0;
      n_layers   <= '0;
      in_base    <= '0;
      out_base   <= '0;
    end else begin
      state <= state_next;
      if (abort) begin
        // Config and result_buf are kept; only the run position is dropped.
        layer_idx <= '0;
        in_sel    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_valid) begin
              n_layers  <= cfg_n_layers;
              in_base   <= cfg_in_base;
              out_base  <= cfg_out_base;
              layer_idx <= '0;
              in_sel    <= 1'b0;
            end
          end
          S_SWAP: begin
            in_sel <= ~in_sel;
            if (!last_layer) layer_idx <= layer_idx + LAYER_W'(1);
          end
          // in_sel already points at the half the last layer wrote.
          S_DONE: result_buf <= in_sel;
          default: ;
        endcase
      end
    end
  end

  // All status outputs decode the registered state only.
  assign cfg_ready   = (state == S_IDLE);
  assign layer_start = (state == S_START);
  assign done        = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign host_acc_ok = (state == S_IDLE) || (state == S_WAIT_LOAD);
  assign state_dbg   = state;

  // The pointers only move in SWAP or on a config/abort, so they hold steady
  // from START through RUN.
  assign input_memory_pointer  = {in_sel, in_base};
  assign output_memory_pointer = {~in_sel, out_base};

endmodule
